// File: rtl/register_key_pkg.sv
// Shared definitions for the lab-board register key controller.
package register_key_pkg;

    // Controller states; the encoding is fixed so debug tools can decode it.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        CLEAR    = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    // Debounce lengths: short for simulation, about 10 ms at 50 MHz on the board.
    localparam int DEBOUNCE_SIM   = 4;
    localparam int DEBOUNCE_BOARD = 500000;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser, debounce counter and rising-edge detector for one key.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic key_i,
    output logic level_o,
    output logic rise_o
);

    // The counter only has to reach DEBOUNCE_CYCLES-1 before the level flips.
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    // Synchronise the raw key, then accept a new level only after it has
    // disagreed with the current one for DEBOUNCE_CYCLES consecutive samples.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_a  <= key_i;
            sync_b  <= sync_a;
            level_q <= level;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= sync_b;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign level_o = level;
    assign rise_o  = level & ~level_q;

endmodule

// File: rtl/register_key_ctrl.sv
// Switch register controller: debounced load/clear keys drive one register
// operation per press, clear taking priority, with a wrapping load counter.
//
// Handshake note: there is no valid/ready pair here. load_o and clear_o are
// single-cycle strobes decoded from the state, so they always coincide with
// the already-updated register_o; the consumer never stalls the controller.
module register_key_ctrl
    import register_key_pkg::*;
#(
    parameter int DATA_W          = 10,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM,
    parameter int CNT_W           = 8
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              key0_i,
    input  logic              key1_i,
    input  logic [DATA_W-1:0] sw_i,
    output logic [DATA_W-1:0] register_o,
    output logic              load_o,
    output logic              clear_o,
    output logic [CNT_W-1:0]  load_cnt_o,
    output logic [1:0]        fsm_state
);

    logic        level0;
    logic        level1;
    logic        rise0;
    logic        rise1;
    state_t      state;
    state_t      state_next;
    logic        do_load;
    logic        do_clear;
    logic [DATA_W-1:0] register_q;
    logic [CNT_W-1:0]  load_cnt;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key0 (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .key_i   (key0_i),
        .level_o (level0),
        .rise_o  (rise0)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .key_i   (key1_i),
        .level_o (level1),
        .rise_o  (rise1)
    );

    // Next-state decode; presses outside IDLE are dropped, clear beats load.
    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        do_clear   = 1'b0;
        case (state)
            IDLE: begin
                if (rise1) begin
                    state_next = CLEAR;
                    do_clear   = 1'b1;
                end else if (rise0) begin
                    state_next = LOAD;
                    do_load    = 1'b1;
                end
            end
            LOAD:     state_next = WAIT_REL;
            CLEAR:    state_next = WAIT_REL;
            WAIT_REL: begin
                if (!level0 && !level1) begin
                    state_next = IDLE;
                end
            end
            default:  state_next = IDLE;
        endcase
    end

    // State register plus the register/counter updates on the IDLE exit edge.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state      <= IDLE;
            register_q <= '0;
            load_cnt   <= '0;
        end else begin
            state <= state_next;
            if (do_clear) begin
                register_q <= '0;
            end else if (do_load) begin
                register_q <= sw_i;
                load_cnt   <= load_cnt + 1'b1;
            end
        end
    end

    assign register_o = register_q;
    assign load_cnt_o = load_cnt;
    assign load_o     = (state == LOAD);
    assign clear_o    = (state == CLEAR);
    assign fsm_state  = state;

endmodule

// File: tb/tb_register_key_ctrl.sv
// Bench for register_key_ctrl: directed scenarios plus random key activity,
// every cycle compared against a behavioural model of the key rules.
module tb_register_key_ctrl;

  localparam int DATA_W = 10;
  localparam int DEB    = 4;
  localparam int CNT_W  = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn = 1'b0;
  logic              key0 = 1'b0;
  logic              key1 = 1'b0;
  logic [DATA_W-1:0] sw   = '0;
  logic [DATA_W-1:0] register_o;
  logic              load_o;
  logic              clear_o;
  logic [CNT_W-1:0]  load_cnt_o;
  logic [1:0]        fsm_state;

  register_key_ctrl #(
    .DATA_W(DATA_W), .DEBOUNCE_CYCLES(DEB), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .key0_i(key0), .key1_i(key1), .sw_i(sw),
    .register_o(register_o), .load_o(load_o), .clear_o(clear_o),
    .load_cnt_o(load_cnt_o), .fsm_state(fsm_state)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Key history: raw samples taken at each edge since the last reset.
  bit h0[$];
  bit h1[$];
  bit m_deb0, m_deb0_old, m_deb1, m_deb1_old;
  logic [DATA_W-1:0] m_reg;
  logic [CNT_W-1:0]  m_cnt;
  bit m_load, m_clear;
  int m_phase;  // 0 ready, 1 just acted, 2 waiting for both keys released

  logic [DATA_W-1:0] exp_q[$];
  int loads_seen  = 0;
  int clears_seen = 0;

  // A key's accepted level flips when its last DEB synchronised samples all
  // disagree with it; the synchronised value lags the raw sample by one edge.
  function automatic bit flips(input int k, input bit lvl);
    int n;
    bit v;
    n = (k == 0) ? h0.size() : h1.size();
    for (int i = n - 1 - DEB; i <= n - 2; i++) begin
      v = (k == 0) ? h0[i] : h1[i];
      if (v == lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit r0, r1, n0, n1;
    if (!rstn) begin
      h0.delete();
      h1.delete();
      for (int i = 0; i < DEB + 2; i++) begin
        h0.push_back(1'b0);
        h1.push_back(1'b0);
      end
      m_deb0 = 0; m_deb0_old = 0; m_deb1 = 0; m_deb1_old = 0;
      m_reg = '0; m_cnt = '0; m_load = 0; m_clear = 0; m_phase = 0;
      exp_q.delete();
    end else begin
      r0 = m_deb0 & ~m_deb0_old;
      r1 = m_deb1 & ~m_deb1_old;
      n0 = flips(0, m_deb0) ? ~m_deb0 : m_deb0;
      n1 = flips(1, m_deb1) ? ~m_deb1 : m_deb1;
      m_load = 0;
      m_clear = 0;
      if (m_phase == 0) begin
        if (r1) begin
          m_reg = '0; m_clear = 1; m_phase = 1; exp_q.push_back(m_reg);
        end else if (r0) begin
          m_reg = sw; m_cnt = m_cnt + 1'b1; m_load = 1; m_phase = 1;
          exp_q.push_back(m_reg);
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (!m_deb0 && !m_deb1) begin
        m_phase = 0;
      end
      m_deb0_old = m_deb0; m_deb0 = n0;
      m_deb1_old = m_deb1; m_deb1 = n1;
      h0.push_back(key0);
      h1.push_back(key1);
      if (h0.size() > 64) begin
        void'(h0.pop_front());
        void'(h1.pop_front());
      end
    end
  endtask

  // ---------------- driver ----------------
  // One clock: inputs were set away from the edge; sample #1 after it.
  task automatic cycle();
    logic [DATA_W-1:0] e;
    @(posedge clk);
    #1;
    model_edge();
    check_eq("register", register_o, m_reg);
    check_eq("load_o", load_o, m_load);
    check_eq("clear_o", clear_o, m_clear);
    check_eq("load_cnt", load_cnt_o, m_cnt);
    if (load_o) loads_seen++;
    if (clear_o) clears_seen++;
    if (load_o || clear_o) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_strobe", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("sb_value", register_o, e);
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // ---------------- stimulus ----------------
  int l0, c0;

  initial begin
    @(negedge clk);
    rstn = 1'b0;
    run(2);
    check_eq("reset_reg", register_o, 0);
    check_eq("reset_cnt", load_cnt_o, 0);
    check_eq("reset_strobes", {load_o, clear_o}, 0);
    rstn = 1'b1;
    run(5);

    // Load with latency check: first sample at i==1, load at edge DEB+3.
    sw = 10'd513;
    key0 = 1'b1;
    l0 = loads_seen;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      if (i == DEB + 2) check_eq("lat_before", register_o, 0);
      if (i == DEB + 3) begin
        check_eq("lat_load", register_o, 513);
        check_eq("lat_strobe", load_o, 1);
      end
      if (i == DEB + 4) check_eq("lat_strobe_end", load_o, 0);
    end
    key0 = 1'b0;
    run(10);
    check_eq("load_once", loads_seen - l0, 1);
    check_eq("load_cnt1", load_cnt_o, 1);

    // Clear.
    c0 = clears_seen;
    key1 = 1'b1; run(10);
    key1 = 1'b0; run(10);
    check_eq("clear_reg", register_o, 0);
    check_eq("clear_once", clears_seen - c0, 1);
    check_eq("clear_keeps_cnt", load_cnt_o, 1);

    // Glitch shorter than the debounce window.
    sw = 10'd1023;
    l0 = loads_seen;
    key0 = 1'b1; run(3);
    key0 = 1'b0; run(10);
    check_eq("glitch_reg", register_o, 0);
    check_eq("glitch_no_load", loads_seen - l0, 0);

    // Simultaneous press: clear wins.
    l0 = loads_seen; c0 = clears_seen;
    key0 = 1'b1; key1 = 1'b1; run(10);
    key0 = 1'b0; key1 = 1'b0; run(10);
    check_eq("simul_reg", register_o, 0);
    check_eq("simul_clear", clears_seen - c0, 1);
    check_eq("simul_no_load", loads_seen - l0, 0);
    check_eq("simul_cnt", load_cnt_o, 1);

    // Held key with switch change and an ignored clear press.
    sw = 10'd1023;
    l0 = loads_seen; c0 = clears_seen;
    key0 = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (i == 25) sw = 10'd5;
      key1 = (i >= 20 && i < 35);
      cycle();
    end
    key0 = 1'b0; key1 = 1'b0; run(10);
    check_eq("held_reg", register_o, 1023);
    check_eq("held_one_load", loads_seen - l0, 1);
    check_eq("held_no_clear", clears_seen - c0, 0);
    key0 = 1'b1; run(10);
    key0 = 1'b0; run(10);
    check_eq("repress_reg", register_o, 5);

    // Reset while waiting for release.
    sw = 10'd300;
    key0 = 1'b1; run(DEB + 5);
    check_eq("pre_reset_state", fsm_state, 3);
    key0 = 1'b0;
    rstn = 1'b0; run(1);
    check_eq("midreset_reg", register_o, 0);
    check_eq("midreset_cnt", load_cnt_o, 0);
    check_eq("midreset_strobes", {load_o, clear_o}, 0);
    rstn = 1'b1; run(10);

    // 256 presses wrap the counter back to zero.
    l0 = loads_seen;
    for (int p = 0; p < 256; p++) begin
      sw = DATA_W'($urandom_range(0, 1023));
      key0 = 1'b1; run(8);
      key0 = 1'b0; run(8);
    end
    check_eq("wrap_loads", loads_seen - l0, 256);
    check_eq("wrap_cnt", load_cnt_o, 0);

    // Key held through reset deassertion counts as a new press.
    sw = 10'd77;
    key0 = 1'b1;
    rstn = 1'b0; run(1);
    rstn = 1'b1; run(12);
    check_eq("held_reset_reg", register_o, 77);
    key0 = 1'b0; run(10);

    // Random key activity.
    for (int r = 0; r < 200; r++) begin
      key0 = 1'($urandom_range(0, 1));
      key1 = ($urandom_range(0, 3) == 0);
      sw   = DATA_W'($urandom_range(0, 1023));
      if ($urandom_range(0, 49) == 0) rstn = 1'b0;
      run($urandom_range(1, 12));
      rstn = 1'b1;
    end
    key0 = 1'b0; key1 = 1'b0; run(20);
    check_eq("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_key_ctrl.md
Name: register_key_ctrl

Overview:
- Controller that sequences the 10-bit switch register on the lab board.
- Synchronises and debounces two push-buttons: key0 = load, key1 = clear.
- Converts each accepted button press into exactly one register operation, with clear winning over load.
- Owns the register value and a load-event counter; sits between the board keys/switches and the LED outputs.

Parameters:
- DATA_W, 10, width of sw_i and register_o.
- DEBOUNCE_CYCLES, 4, consecutive identical synchronised samples needed to accept a new key level (≥1; board build overrides to 500000).
- CNT_W, 8, width of the load-event counter.

Ports:
- clk_i  input  1  system clock, all logic on rising edge.
- rstn_i  input  1  reset, synchronous, active-low.
- key0_i  input  1  raw load button, active-high, asynchronous to clk_i.
- key1_i  input  1  raw clear button, active-high, asynchronous to clk_i.
- sw_i  input  DATA_W  switch value to be loaded.
- register_o  output  DATA_W  stored register value.
- load_o  output  1  one-cycle strobe: register_o has just been loaded.
- clear_o  output  1  one-cycle strobe: register_o has just been cleared.
- load_cnt_o  output  CNT_W  number of accepted loads, modulo 2^CNT_W.

Behaviour:
- Reset (rstn_i=0 at a rising edge):
  - register_o=0, load_o=0, clear_o=0, load_cnt_o=0.
  - FSM=IDLE; sync flops, debounced levels and debounce counters all 0.
  - Reset mid-operation aborts any pending or in-progress operation.
- Synchroniser: two flops per key; only the second-stage output (syncN) is used downstream.
- Debounce, per key:
  - Counter increments each cycle that syncN differs from debN.
  - Counter clears to 0 on any cycle where syncN equals debN.
  - When the counter would reach DEBOUNCE_CYCLES, debN takes syncN and the counter clears.
  - Pulses shorter than DEBOUNCE_CYCLES cycles are ignored.
- Press detection: rise = debN & ~debN_q (one cycle).
- FSM states: IDLE, LOAD, CLEAR, WAIT_REL.
  - IDLE, rise1 → CLEAR; register_o←0 on the same edge.
  - IDLE, rise0 and no rise1 → LOAD; register_o←sw_i on the same edge, load_cnt_o increments on the same edge.
  - LOAD: load_o=1 for one cycle → WAIT_REL.
  - CLEAR: clear_o=1 for one cycle → WAIT_REL.
  - WAIT_REL: stays until deb0=0 and deb1=0, then → IDLE.
- Strobe timing: load_o and clear_o are decoded from the state, so each strobe is coincident with the already-updated register_o.
- Simultaneous rise0 and rise1 in IDLE: clear wins, the load is discarded.
- Presses during LOAD, CLEAR or WAIT_REL are ignored. They are not queued, including a press of the other key while one is held.
- Latency: a clean key0_i rise first sampled at edge 1 loads register_o at edge DEBOUNCE_CYCLES+3; load_o is high in the following cycle.
- sw_i is sampled only at the IDLE→LOAD edge. Later sw_i changes do not affect register_o.
- load_cnt_o wraps 2^CNT_W−1 → 0 and is not affected by clear.
- A key held through reset deassertion debounces as a new press and is accepted after the normal latency.

Decomposition:
- Shared package (register_key_pkg):
  - FSM state encoding constants IDLE=2'd0, LOAD=2'd1, CLEAR=2'd2, WAIT_REL=2'd3.
  - Default DEBOUNCE_CYCLES values for simulation and board.
- Sub-module key_debounce (parameter DEBOUNCE_CYCLES; ports clk_i, rstn_i, key_i, level_o, rise_o):
  - Contains the synchroniser, debounce counter and edge detector.
  - Instantiated twice in the top.

Test Plan (DEBOUNCE_CYCLES=4):
- Load: sw_i=513, key0_i high 10 cycles → register_o=513 at edge 7 after first sampling; load_o high exactly 1 cycle; load_cnt_o=1.
- Clear: after the load above, key1_i high 10 cycles → register_o=0, clear_o one cycle, load_cnt_o stays 1.
- Glitch: key0_i high 3 cycles then low, sw_i=1023 → register_o unchanged, load_o never asserts.
- Simultaneous press: sw_i=1023, key0_i and key1_i rise on the same edge → register_o=0, clear_o once, load_o never asserts, load_cnt_o unchanged.
- Held key:
  - key0_i held 50 cycles, sw_i changed 1023→5 mid-hold → exactly one load, register_o=1023.
  - key1_i pressed during the hold → ignored.
  - Release both, press key0_i → register_o=5.
- Reset and wrap:
  - rstn_i=0 for 1 cycle during WAIT_REL → all outputs 0.
  - Then 256 separate key0_i presses → load_cnt_o wraps to 0.
